// File: rtl/fpu_pkg.sv
// Shared FPU types: fused-op encoding, single-precision word, sign helper.
package fpu_pkg;

  localparam int unsigned SIGN_BIT = 31;

  typedef logic [31:0] fp32_t;

  typedef enum logic [1:0] {
    FMADD  = 2'd0,
    FMSUB  = 2'd1,
    FNMSUB = 2'd2,
    FNMADD = 2'd3
  } fma_op_t;

  // Raw sign flip: applied to NaN/zero/inf alike, no classification.
  function automatic fp32_t flip_sign(input fp32_t x);
    return {~x[SIGN_BIT], x[SIGN_BIT-1:0]};
  endfunction

endpackage

// File: rtl/fma_res_fifo.sv
// Result FIFO with show-ahead read; simultaneous write/read allowed at any fill.
module fma_res_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  // Pointer and occupancy tracking; pointers wrap naturally at a power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; no reset needed since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];

endmodule

// File: rtl/fma_issue.sv
// Issue/tracking stage for the fixed-latency fused multiply-subtract datapath.
module fma_issue
  import fpu_pkg::*;
#(
  parameter int unsigned FMA_LAT   = 4,
  parameter int unsigned RES_DEPTH = 4,
  parameter int unsigned TAG_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  fma_op_t          req_op,
  input  logic [31:0]      req_x1,
  input  logic [31:0]      req_x2,
  input  logic [31:0]      req_x3,
  input  logic [TAG_W-1:0] req_rd,
  output logic [31:0]      dp_x1,
  output logic [31:0]      dp_x2,
  output logic [31:0]      dp_x3,
  input  logic [31:0]      dp_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_y,
  output logic [TAG_W-1:0] res_rd,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(RES_DEPTH + 1);

  logic             accept;
  logic             res_fire;
  logic [CNT_W-1:0] outstanding;
  fp32_t            map_x1;
  fp32_t            map_x3;
  logic [FMA_LAT:0] pipe_v;
  logic [TAG_W-1:0] pipe_rd [FMA_LAT+1];
  logic [TAG_W+31:0] fifo_rd_data;

  // Credits cover in-flight plus buffered ops, so the FIFO write needs no full check.
  assign req_ready = (outstanding < CNT_W'(RES_DEPTH));
  assign accept    = req_valid && req_ready;
  assign res_fire  = res_valid && res_ready;
  assign busy      = (outstanding != '0);

  // Outstanding-request credit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({accept, res_fire})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Map each fused op onto x1*x2 - x3 by flipping operand signs.
  always_comb begin
    map_x1 = req_x1;
    map_x3 = req_x3;
    case (req_op)
      FMADD:   map_x3 = flip_sign(req_x3);
      FMSUB:   map_x3 = req_x3;
      FNMSUB: begin
        map_x1 = flip_sign(req_x1);
        map_x3 = flip_sign(req_x3);
      end
      FNMADD:  map_x1 = flip_sign(req_x1);
      default: map_x1 = req_x1;
    endcase
  end

  // Datapath operand registers; hold between accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_x1 <= '0;
      dp_x2 <= '0;
      dp_x3 <= '0;
    end else if (accept) begin
      dp_x1 <= map_x1;
      dp_x2 <= req_x2;
      dp_x3 <= map_x3;
    end
  end

  // Valid shift pipe aligned so stage FMA_LAT coincides with the matching dp_y.
  always_ff @(posedge clk) begin
    if (rst) pipe_v <= '0;
    else     pipe_v <= {pipe_v[FMA_LAT-1:0], accept};
  end

  // Tag shift pipe; only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    pipe_rd[0] <= req_rd;
    for (int unsigned i = 1; i <= FMA_LAT; i++) pipe_rd[i] <= pipe_rd[i-1];
  end

  fma_res_fifo #(
    .DEPTH(RES_DEPTH),
    .WIDTH(TAG_W + 32)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (pipe_v[FMA_LAT]),
    .wr_data ({pipe_rd[FMA_LAT], dp_y}),
    .rd_en   (res_fire),
    .rd_valid(res_valid),
    .rd_data (fifo_rd_data)
  );

  assign res_rd = fifo_rd_data[TAG_W+31:32];
  assign res_y  = fifo_rd_data[31:0];

endmodule

// File: tb/tb_fma_issue.sv
// Self-checking bench for fma_issue with a behavioural x1*x2-x3 datapath and result scoreboard.
module tb_fma_issue;
  import fpu_pkg::*;

  localparam int unsigned FMA_LAT = 4;
  localparam int unsigned RES_DEPTH = 4;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned S_DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, s_req_valid = 1'b0;
  logic req_ready, s_req_ready;
  fma_op_t req_op = FMSUB;
  logic [31:0] req_x1 = '0, req_x2 = '0, req_x3 = '0;
  logic [TAG_W-1:0] req_rd = '0;
  logic [31:0] dp_x1, dp_x2, dp_x3, dp_y;
  logic [31:0] s_dp_x1, s_dp_x2, s_dp_x3, s_dp_y;
  logic res_valid, s_res_valid;
  logic res_ready = 1'b0;
  logic [31:0] res_y, s_res_y;
  logic [TAG_W-1:0] res_rd, s_res_rd;
  logic busy, s_busy;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_y_q[$];
  logic [TAG_W-1:0] exp_rd_q[$];
  int m_out = 0;
  logic [31:0] vals [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                            32'h40800000, 32'h3F000000, 32'h40A00000};

  always #5 clk = ~clk;

  fma_issue #(.FMA_LAT(FMA_LAT), .RES_DEPTH(RES_DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x1(req_x1), .req_x2(req_x2), .req_x3(req_x3), .req_rd(req_rd),
    .dp_x1(dp_x1), .dp_x2(dp_x2), .dp_x3(dp_x3), .dp_y(dp_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_rd(res_rd), .busy(busy));

  // Deeper instance: sustained 1 op/cycle needs RES_DEPTH >= FMA_LAT+2 credits.
  fma_issue #(.FMA_LAT(FMA_LAT), .RES_DEPTH(S_DEPTH), .TAG_W(TAG_W)) dut_s (
    .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_ready(s_req_ready), .req_op(req_op),
    .req_x1(req_x1), .req_x2(req_x2), .req_x3(req_x3), .req_rd(req_rd),
    .dp_x1(s_dp_x1), .dp_x2(s_dp_x2), .dp_x3(s_dp_x3), .dp_y(s_dp_y),
    .res_valid(s_res_valid), .res_ready(res_ready), .res_y(s_res_y), .res_rd(s_res_rd), .busy(s_busy));

  function automatic real sp2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:0] == 31'd0) d = {b[31], 63'd0};
    else d = {b[31], 11'({3'b000, b[30:23]} + 11'd896), b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fused(input fma_op_t op, input logic [31:0] a, b, c);
    real p, rc;
    p = sp2r(a) * sp2r(b);
    rc = sp2r(c);
    case (op)
      FMADD:   return r2sp(p + rc);
      FMSUB:   return r2sp(p - rc);
      FNMSUB:  return r2sp(-p + rc);
      default: return r2sp(-p - rc);
    endcase
  endfunction

  logic [31:0] dp_pipe [FMA_LAT];
  logic [31:0] s_dp_pipe [FMA_LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= r2sp(sp2r(dp_x1) * sp2r(dp_x2) - sp2r(dp_x3));
    s_dp_pipe[0] <= r2sp(sp2r(s_dp_x1) * sp2r(s_dp_x2) - sp2r(s_dp_x3));
    for (int i = 1; i < int'(FMA_LAT); i++) begin
      dp_pipe[i] <= dp_pipe[i-1];
      s_dp_pipe[i] <= s_dp_pipe[i-1];
    end
  end
  assign dp_y = dp_pipe[FMA_LAT-1];
  assign s_dp_y = s_dp_pipe[FMA_LAT-1];

  // Scoreboard and credit model for the main instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_y_q.delete();
      exp_rd_q.delete();
      m_out = 0;
    end else begin
      tests++;
      if (req_ready !== (m_out < int'(RES_DEPTH)) || busy !== (m_out != 0)) begin
        fails++;
        $display("FAIL credit: req_ready=%b busy=%b expected outstanding=%0d", req_ready, busy, m_out);
      end
      if (res_valid && res_ready) begin
        tests++;
        if (exp_y_q.size() == 0) begin
          fails++;
          $display("FAIL result_unexpected: y=%h rd=%0d with empty scoreboard", res_y, res_rd);
        end else begin
          if (res_y !== exp_y_q[0] || res_rd !== exp_rd_q[0]) begin
            fails++;
            $display("FAIL result: got y=%h rd=%0d expected y=%h rd=%0d", res_y, res_rd, exp_y_q[0], exp_rd_q[0]);
          end
          void'(exp_y_q.pop_front());
          void'(exp_rd_q.pop_front());
        end
        m_out--;
      end
      if (req_valid && req_ready) begin
        exp_y_q.push_back(fused(req_op, req_x1, req_x2, req_x3));
        exp_rd_q.push_back(req_rd);
        m_out++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req();
    logic [31:0] t;
    req_op = fma_op_t'($urandom_range(0, 3));
    t = vals[$urandom_range(0, 5)]; req_x1 = {1'($urandom_range(0, 1)), t[30:0]};
    t = vals[$urandom_range(0, 5)]; req_x2 = {1'($urandom_range(0, 1)), t[30:0]};
    t = vals[$urandom_range(0, 5)]; req_x3 = {1'($urandom_range(0, 1)), t[30:0]};
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    tests++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 ||
        dp_x1 !== '0 || dp_x2 !== '0 || dp_x3 !== '0) begin
      fails++;
      $display("FAIL reset_state: res_valid=%b busy=%b req_ready=%b dp=%h/%h/%h expected 0/0/1/0", res_valid, busy, req_ready, dp_x1, dp_x2, dp_x3);
    end
  endtask

  task automatic test_ops();
    fma_op_t ops [4] = '{FMSUB, FMADD, FNMADD, FNMSUB};
    logic [31:0] ex1 [4] = '{32'h40000000, 32'h40000000, 32'hC0000000, 32'hC0000000};
    logic [31:0] ex3 [4] = '{32'h3F800000, 32'hBF800000, 32'h3F800000, 32'hBF800000};
    logic [31:0] ey  [4] = '{32'h40A00000, 32'h40E00000, 32'hC0E00000, 32'hC0A00000};
    for (int n = 0; n < 4; n++) begin
      req_op = ops[n]; req_x1 = 32'h40000000; req_x2 = 32'h40400000; req_x3 = 32'h3F800000;
      req_rd = 5'd7; req_valid = 1'b1; res_ready = 1'b1;
      cyc();
      req_valid = 1'b0;
      tests++;
      if (dp_x1 !== ex1[n] || dp_x2 !== 32'h40400000 || dp_x3 !== ex3[n]) begin
        fails++;
        $display("FAIL op_map[%0d]: dp=%h/%h/%h expected %h/40400000/%h", n, dp_x1, dp_x2, dp_x3, ex1[n], ex3[n]);
      end
      for (int k = 1; k <= 5; k++) begin
        cyc();
        if (k == 4) begin
          tests++;
          if (res_valid !== 1'b0) begin
            fails++;
            $display("FAIL op_early[%0d]: res_valid=%b expected 0", n, res_valid);
          end
        end
        if (k == 5) begin
          tests++;
          if (res_valid !== 1'b1 || res_y !== ey[n] || res_rd !== 5'd7) begin
            fails++;
            $display("FAIL op_result[%0d]: valid=%b y=%h rd=%0d expected 1 %h 7", n, res_valid, res_y, res_rd, ey[n]);
          end
        end
      end
      cyc(); cyc();
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int tag = 0;
    int exp_tag;
    res_ready = 1'b0; req_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      req_rd = TAG_W'(tag); rand_req();
      if (req_ready) begin acc++; tag++; end
      cyc();
    end
    tests++;
    if (acc != 4 || req_ready !== 1'b0 || busy !== 1'b1 || res_valid !== 1'b1 || res_rd !== 5'd0) begin
      fails++;
      $display("FAIL bp_full: accepts=%0d req_ready=%b busy=%b res_valid=%b rd=%0d expected 4 0 1 1 0", acc, req_ready, busy, res_valid, res_rd);
    end
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    req_rd = TAG_W'(tag); rand_req();
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_credit: req_ready=%b expected 1", req_ready);
    end
    cyc();
    req_valid = 1'b0;
    res_ready = 1'b1;
    exp_tag = 1;
    for (int c = 0; c < 20; c++) begin
      if (res_valid) begin
        tests++;
        if (res_rd !== TAG_W'(exp_tag)) begin
          fails++;
          $display("FAIL bp_order: rd=%0d expected %0d", res_rd, exp_tag);
        end
        exp_tag++;
      end
      cyc();
    end
    tests++;
    if (exp_tag != 5 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bp_drain: next_tag=%0d busy=%b expected 5 0", exp_tag, busy);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] sy_q[$];
    int got = 0;
    int gaps = 0;
    bit started = 0;
    res_ready = 1'b1;
    for (int c = 0; c < 40 && got < 16; c++) begin
      if (c < 16) begin
        req_rd = TAG_W'(c); rand_req(); s_req_valid = 1'b1;
        tests++;
        if (s_req_ready !== 1'b1) begin
          fails++;
          $display("FAIL stream_ready[%0d]: req_ready=%b expected 1", c, s_req_ready);
        end
        sy_q.push_back(fused(req_op, req_x1, req_x2, req_x3));
      end else begin
        s_req_valid = 1'b0;
      end
      if (s_res_valid) begin
        tests++;
        if (sy_q.size() == 0 || s_res_y !== sy_q[0] || s_res_rd !== TAG_W'(got)) begin
          fails++;
          $display("FAIL stream_result[%0d]: y=%h rd=%0d expected rd=%0d", got, s_res_y, s_res_rd, got);
        end
        if (sy_q.size() != 0) void'(sy_q.pop_front());
        got++;
        started = 1;
      end else if (started) begin
        gaps++;
      end
      cyc();
    end
    s_req_valid = 1'b0;
    tests++;
    if (got != 16 || gaps != 0) begin
      fails++;
      $display("FAIL stream_count: results=%0d gaps=%0d expected 16 0", got, gaps);
    end
  endtask

  task automatic test_simul_random();
    int acc = 0;
    res_ready = 1'b0; req_valid = 1'b1;
    for (int c = 0; c < 10 && acc < 4; c++) begin
      req_rd = TAG_W'($urandom_range(0, 31)); rand_req();
      if (req_ready) acc++;
      cyc();
    end
    req_valid = 1'b0;
    for (int c = 0; c < 8; c++) cyc();
    req_valid = 1'b1; res_ready = 1'b1;
    req_rd = TAG_W'($urandom_range(0, 31)); rand_req();
    cyc();
    tests++;
    if (req_ready !== 1'b1 || res_valid !== 1'b1) begin
      fails++;
      $display("FAIL simul_pop: req_ready=%b res_valid=%b expected 1 1", req_ready, res_valid);
    end
    req_rd = TAG_W'($urandom_range(0, 31)); rand_req();
    cyc();
    tests++;
    if (req_ready !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL simul_both: req_ready=%b busy=%b expected 1 1", req_ready, busy);
    end
    for (int c = 0; c < 80; c++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      res_ready = 1'($urandom_range(0, 1));
      req_rd = TAG_W'($urandom_range(0, 31)); rand_req();
      cyc();
    end
    req_valid = 1'b0; res_ready = 1'b1;
    for (int c = 0; c < 20; c++) cyc();
    tests++;
    if (exp_y_q.size() != 0 || res_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL random_drain: pending=%0d res_valid=%b busy=%b expected 0 0 0", exp_y_q.size(), res_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b0; req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      req_rd = TAG_W'(c); rand_req(); req_x1 = 32'h40400000;
      cyc();
    end
    req_valid = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    tests++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 ||
        dp_x1 !== '0 || dp_x2 !== '0 || dp_x3 !== '0) begin
      fails++;
      $display("FAIL mid_reset: res_valid=%b busy=%b req_ready=%b dp=%h/%h/%h expected 0/0/1/0", res_valid, busy, req_ready, dp_x1, dp_x2, dp_x3);
    end
    res_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc();
      tests++;
      if (res_valid !== 1'b0) begin
        fails++;
        $display("FAIL stale_result[%0d]: res_valid=%b rd=%0d expected 0", c, res_valid, res_rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_backpressure();
    test_streaming();
    test_simul_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
